// File: rtl/jump_table_loader_if.sv
// Stream-in / table-write bundle for jump_table_loader.
// master = the loader itself, slave = whoever feeds bytes and watches the write port.
interface jump_table_loader_if #(
  parameter int addr_width = 8,
  parameter int data_width = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [addr_width-1:0] wr_adr;
  logic [data_width-1:0] wr_dat;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_adr, wr_dat, busy, done, err
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_adr, wr_dat, busy, done, err
  );
endinterface

// File: rtl/jump_table_loader.sv
// Jump table writer: parses SYNC/ADDR/LEN/DATA[/CHK] frames into sequential table writes.
// Define JUMP_LOADER_CHECKSUM_EN to require a trailing checksum byte and drive err.
module jump_table_loader #(
  parameter int         addr_width = 8,
  parameter int         data_width = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  jump_table_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
`ifdef JUMP_LOADER_CHECKSUM_EN
    S_CHK  = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  function automatic logic [7:0] sum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [addr_width-1:0] ptr_inc(input logic [addr_width-1:0] p);
    return p + addr_width'(1);
  endfunction

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [8:0]            count_q, count_d;
  logic [7:0]            sum_q, sum_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [addr_width-1:0] wr_adr_q, wr_adr_d;
  logic [data_width-1:0] wr_dat_q, wr_dat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef JUMP_LOADER_CHECKSUM_EN
  logic                  err_q, err_d;
`endif
  logic                  xfer;

  assign xfer = bus.in_valid & in_ready_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    sum_d    = sum_q;
    wr_en_d  = 1'b0;
    wr_adr_d = wr_adr_q;
    wr_dat_d = wr_dat_q;
`ifdef JUMP_LOADER_CHECKSUM_EN
    err_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // Anything other than the marker is swallowed so a desynced host can resync.
        if (xfer && (bus.in_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (xfer) begin
          ptr_d   = bus.in_data[addr_width-1:0];
          sum_d   = bus.in_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (xfer) begin
          count_d = {1'b0, bus.in_data};
          sum_d   = sum_add(sum_q, bus.in_data);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_en_d  = 1'b1;
          wr_adr_d = ptr_q;
          wr_dat_d = data_width'(bus.in_data);
          ptr_d    = ptr_inc(ptr_q);
          sum_d    = sum_add(sum_q, bus.in_data);
          if (count_q == 9'd0) begin
`ifdef JUMP_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            count_d = count_q - 9'd1;
          end
        end
      end
`ifdef JUMP_LOADER_CHECKSUM_EN
      S_CHK: begin
        // Writes already landed; a bad checksum is only reported, never undone.
        if (xfer) begin
          err_d   = (sum_add(sum_q, bus.in_data) != 8'h00);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered, so derive them from the state being entered.
    in_ready_d = (state_d != S_DONE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef JUMP_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef JUMP_LOADER_CHECKSUM_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_adr   = wr_adr_q;
  assign bus.wr_dat   = wr_dat_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef JUMP_LOADER_CHECKSUM_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_jump_table_loader.sv
// Directed bench for jump_table_loader; adapts frame contents to JUMP_LOADER_CHECKSUM_EN.
module tb_jump_table_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jump_table_loader_if #(.addr_width(AW), .data_width(8)) ifc ();

  jump_table_loader #(.addr_width(AW), .data_width(8), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  logic [7:0] log_adr [1024];
  logic [7:0] log_dat [1024];
  int         log_cyc [1024];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port recorder; tests compare against entries past their own start index.
  always @(negedge clk) begin
    if (ifc.wr_en === 1'b1 && wr_cnt < 1024) begin
      log_adr[wr_cnt] = ifc.wr_adr;
      log_dat[wr_cnt] = ifc.wr_dat;
      log_cyc[wr_cnt] = cyc;
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    while (ifc.in_ready !== 1'b1 && t < 20) begin
      step(1);
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL send_byte: in_ready=%b stuck, required 1 (byte %h)", ifc.in_ready, b);
    end
    step(1);
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    ifc.in_valid = 1'b0;
    while (ifc.done !== 1'b1 && t < 600) begin
      step(1);
      t++;
    end
    ok = (ifc.done === 1'b1);
  endtask

  task automatic test_reset;
    int base;
    bit ok;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    step(2);
    checks++;
    if (ifc.wr_en !== 1'b0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: wr_en=%b busy=%b done=%b err=%b, required all 0",
               ifc.wr_en, ifc.busy, ifc.done, ifc.err);
    end
    checks++;
    if (ifc.wr_adr !== 8'h00 || ifc.wr_dat !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: wr_adr=%h wr_dat=%h, required 00 00", ifc.wr_adr, ifc.wr_dat);
    end
    checks++;
    if (ifc.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: in_ready=%b, required 0", ifc.in_ready);
    end
    rst = 1'b0;
    step(1);
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_high: in_ready=%b, required 1", ifc.in_ready);
    end

    // Abort in the middle of DATA: two of six entries written, then reset for two cycles.
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    step(1);
    checks++;
    if (ifc.wr_en !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: wr_en=%b busy=%b, required 0 0", ifc.wr_en, ifc.busy);
    end
    step(1);
    rst = 1'b0;
    step(1);
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: in_ready=%b busy=%b wr_en=%b, required 1 0 0",
               ifc.in_ready, ifc.busy, ifc.wr_en);
    end
    checks++;
    if (wr_cnt - base != 2 || log_adr[base] !== 8'h20 || log_dat[base] !== 8'h01 ||
        log_adr[base+1] !== 8'h21 || log_dat[base+1] !== 8'h02) begin
      errors++;
      $display("FAIL midreset_writes: count=%0d first=%h:%h, required 2 writes 20:01 21:02",
               wr_cnt - base, log_adr[base], log_dat[base]);
    end

    // A fresh frame must parse from SYNC again.
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'h44);
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'h8C);
`endif
    wait_done(ok);
    step(1);
    checks++;
    if (!ok || wr_cnt - base != 1 || log_adr[base] !== 8'h30 || log_dat[base] !== 8'h44) begin
      errors++;
      $display("FAIL postreset_frame: done_seen=%0d count=%0d write=%h:%h, required 1 write 30:44",
               ok, wr_cnt - base, log_adr[base], log_dat[base]);
    end
  endtask

  task automatic test_stream;
    int base;
    bit ok;
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    ea[0] = 8'h10; ea[1] = 8'h11; ea[2] = 8'h12;
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'h88);
`endif
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stream_done: done=%b after timeout, required 1", ifc.done);
    end
    checks++;
    if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1 || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_cycle: in_ready=%b busy=%b err=%b, required 0 1 0",
               ifc.in_ready, ifc.busy, ifc.err);
    end
`ifdef JUMP_LOADER_CHECKSUM_EN
    checks++;
    if (ifc.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stream_chk_nowrite: wr_en=%b at done, required 0", ifc.wr_en);
    end
`else
    checks++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_adr !== 8'h12 || ifc.wr_dat !== 8'h33) begin
      errors++;
      $display("FAIL stream_last_with_done: wr_en=%b %h:%h, required 1 12:33",
               ifc.wr_en, ifc.wr_adr, ifc.wr_dat);
    end
`endif
    step(1);
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_after: done=%b busy=%b in_ready=%b, required 0 0 1",
               ifc.done, ifc.busy, ifc.in_ready);
    end
    checks++;
    if (wr_cnt - base != 3) begin
      errors++;
      $display("FAIL stream_count: %0d writes, required 3", wr_cnt - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_adr[base+i] !== ea[i] || log_dat[base+i] !== ed[i]) begin
        errors++;
        $display("FAIL stream_write%0d: %h:%h, required %h:%h",
                 i, log_adr[base+i], log_dat[base+i], ea[i], ed[i]);
      end
    end
    checks++;
    if (log_cyc[base+1] != log_cyc[base] + 1 || log_cyc[base+2] != log_cyc[base] + 2) begin
      errors++;
      $display("FAIL stream_consecutive: cycles %0d %0d %0d, required consecutive",
               log_cyc[base], log_cyc[base+1], log_cyc[base+2]);
    end
  endtask

  task automatic test_wrap;
    int base;
    bit ok;
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00;
    ed[0] = 8'hAA; ed[1] = 8'hBB; ed[2] = 8'hCC;
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'hCF);
`endif
    wait_done(ok);
    step(1);
    checks++;
    if (!ok || wr_cnt - base != 3) begin
      errors++;
      $display("FAIL wrap_count: done_seen=%0d writes=%0d, required 1 3", ok, wr_cnt - base);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_adr[base+i] !== ea[i] || log_dat[base+i] !== ed[i]) begin
        errors++;
        $display("FAIL wrap_write%0d: %h:%h, required %h:%h",
                 i, log_adr[base+i], log_dat[base+i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_garbage_gaps;
    int base;
    bit ok;
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00);
    ifc.in_valid = 1'b0;
    step(2);
    checks++;
    if (ifc.wr_en !== 1'b0 || ifc.busy !== 1'b1 || wr_cnt != base) begin
      errors++;
      $display("FAIL gap_hold: wr_en=%b busy=%b writes=%0d, required 0 1 0",
               ifc.wr_en, ifc.busy, wr_cnt - base);
    end
    send_byte(8'h77);
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'h84);
`endif
    wait_done(ok);
    step(1);
    checks++;
    if (!ok || wr_cnt - base != 1 || log_adr[base] !== 8'h05 || log_dat[base] !== 8'h77) begin
      errors++;
      $display("FAIL garbage_write: done_seen=%0d writes=%0d first=%h:%h, required 1 write 05:77",
               ok, wr_cnt - base, log_adr[base], log_dat[base]);
    end
  endtask

  task automatic test_checksum;
    int base;
    bit ok;
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'hD0);
`endif
    wait_done(ok);
    checks++;
    if (!ok || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL chk_good: done_seen=%0d err=%b, required 1 0", ok, ifc.err);
    end
    step(1);
    checks++;
    if (wr_cnt - base != 1 || log_adr[base] !== 8'h10 || log_dat[base] !== 8'h20) begin
      errors++;
      $display("FAIL chk_good_write: writes=%0d %h:%h, required 1 write 10:20",
               wr_cnt - base, log_adr[base], log_dat[base]);
    end
`ifdef JUMP_LOADER_CHECKSUM_EN
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'hD1);
    wait_done(ok);
    checks++;
    if (!ok || ifc.err !== 1'b1) begin
      errors++;
      $display("FAIL chk_bad: done_seen=%0d err=%b, required 1 1", ok, ifc.err);
    end
    step(1);
    checks++;
    if (ifc.err !== 1'b0 || wr_cnt - base != 1 || log_adr[base] !== 8'h10 || log_dat[base] !== 8'h20) begin
      errors++;
      $display("FAIL chk_bad_write: err=%b writes=%0d %h:%h, required err 0 and 1 write 10:20",
               ifc.err, wr_cnt - base, log_adr[base], log_dat[base]);
    end
`endif
  endtask

  task automatic test_full_table;
    int base;
    bit ok;
    logic [7:0] s;
    logic [7:0] d;
    int bad;
    base = wr_cnt;
    s = 8'h00 + 8'hFF;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'h5A;
      s = s + d;
      send_byte(d);
    end
`ifdef JUMP_LOADER_CHECKSUM_EN
    send_byte(8'h00 - s);
`endif
    wait_done(ok);
    checks++;
    if (!ok || ifc.err !== 1'b0) begin
      errors++;
      $display("FAIL full_done: done_seen=%0d err=%b, required 1 0", ok, ifc.err);
    end
    step(1);
    checks++;
    if (wr_cnt - base != 256) begin
      errors++;
      $display("FAIL full_count: %0d writes, required 256", wr_cnt - base);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i) ^ 8'h5A;
      checks++;
      if (log_adr[base+i] !== 8'(i) || log_dat[base+i] !== d) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL full_write%0d: %h:%h, required %h:%h",
                   i, log_adr[base+i], log_dat[base+i], 8'(i), d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    test_reset();
    test_stream();
    test_wrap();
    test_garbage_gaps();
    test_checksum();
    test_full_table();
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
